// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: control and registered output stage for an SRL-based FIFO.
// The shift register itself lives outside this block; here we steer its
// shift enable and read address, count occupancy, and keep the oldest word
// in a first-word-fall-through output register (capacity DEPTH+1 words).
module srl_fifo_ctrl #(
   parameter int DATA_WIDTH   = 1,
   parameter int ADDR_WIDTH   = 3,
   parameter int DEPTH        = 8,
   parameter int AFULL_THRESH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   output logic                  if_full_n,
   output logic                  if_almost_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic                  if_empty_n,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic [ADDR_WIDTH:0]   usedw,
   output logic                  srl_we,
   output logic [ADDR_WIDTH-1:0] srl_addr,
   input  logic [DATA_WIDTH-1:0] srl_dout
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH:0]   srl_count;
   logic [ADDR_WIDTH:0]   count_m1;
   logic                  vld_p0;
   logic [DATA_WIDTH-1:0] dout_p0;
   logic                  push;
   logic                  pop;
   logic                  load;

   // Handshakes, SRL steering and occupancy, all decoded from current state.
   always_comb begin
      // full_n is held low during reset so upstream never writes into a clearing FIFO
      if_full_n        = ~reset & (srl_count != FULL_CNT);
      push             = if_write & if_write_ce & if_full_n;
      pop              = if_read & if_read_ce & vld_p0;
      // refill the output register whenever it is empty or being drained
      load             = (srl_count != '0) & (~vld_p0 | pop);
      count_m1         = srl_count - ONE;
      // oldest SRL word sits at the deepest occupied stage
      srl_addr         = (srl_count != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;
      srl_we           = push;
      usedw            = srl_count + {{ADDR_WIDTH{1'b0}}, vld_p0};
      if_almost_full_n = (int'(usedw) < AFULL_THRESH);
      if_empty_n       = vld_p0;
      if_dout          = dout_p0;
   end

   // SRL occupancy and output register; a simultaneous push and load leaves the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         srl_count <= '0;
         vld_p0    <= 1'b0;
         dout_p0   <= '0;
      end else begin
         case ({push, load})
            2'b10:   srl_count <= srl_count + ONE;
            2'b01:   srl_count <= srl_count - ONE;
            default: srl_count <= srl_count;
         endcase
         if (load) begin
            dout_p0 <= srl_dout;
            vld_p0  <= 1'b1;
         end else if (pop) begin
            vld_p0  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Bench for srl_fifo_ctrl: external SRL storage model, word-level reference
// model with a data scoreboard, directed scenarios and a randomized phase.
module tb_srl_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AFT   = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr, wce, rd, rce;
   logic [DW-1:0] din;
   logic          if_full_n, if_almost_full_n, if_empty_n, srl_we;
   logic [DW-1:0] if_dout, srl_dout;
   logic [AW:0]   usedw;
   logic [AW-1:0] srl_addr;

   int errors = 0;
   int checks = 0;

   srl_fifo_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AFULL_THRESH(AFT)
   ) dut (
      .clk(clk), .reset(reset),
      .if_write_ce(wce), .if_write(wr),
      .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n),
      .if_read_ce(rce), .if_read(rd),
      .if_empty_n(if_empty_n), .if_dout(if_dout),
      .usedw(usedw), .srl_we(srl_we), .srl_addr(srl_addr), .srl_dout(srl_dout)
   );

   always #5 clk = ~clk;

   // External shift-register storage: newest word enters stage 0
   logic [DW-1:0] mem [DEPTH];
   initial foreach (mem[i]) mem[i] = '0;
   always @(posedge clk) begin
      if (srl_we) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
   end
   assign srl_dout = mem[srl_addr];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: number of words held, and whether the head word is
   // already presented on the output. Scoreboard holds the words in order.
   int            m_total = 0;
   bit            m_head  = 0;
   logic [DW-1:0] exp_q[$];
   int            m_sc;
   bit            m_push, m_pop, m_load;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_total = 0;
         m_head  = 0;
         exp_q.delete();
      end else begin
         m_sc   = m_total - int'(m_head);
         m_push = wr && wce && (m_sc != DEPTH);
         m_pop  = rd && rce && m_head;
         m_load = (m_sc != 0) && (!m_head || m_pop);
         if (m_push) exp_q.push_back(din);
         m_total = m_total + int'(m_push) - int'(m_pop);
         if (m_load)     m_head = 1;
         else if (m_pop) m_head = 0;
      end
   end

   // Monitor: compares every output against the model mid-cycle and checks
   // each word the DUT hands out against the scoreboard.
   int            e_sc;
   bit            e_full_n;
   logic [DW-1:0] e_word;
   always @(negedge clk) begin
      e_sc     = m_total - int'(m_head);
      e_full_n = !reset && (e_sc != DEPTH);
      chk("usedw", int'(usedw), m_total);
      chk("empty_n", int'(if_empty_n), int'(m_head));
      chk("full_n", int'(if_full_n), int'(e_full_n));
      chk("afull_n", int'(if_almost_full_n), int'(m_total < AFT));
      chk("srl_we", int'(srl_we), int'(e_full_n && wr && wce));
      chk("srl_addr", int'(srl_addr), (e_sc > 0) ? e_sc - 1 : 0);
      if (if_empty_n && rd && rce) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_data: got %0d expected none (scoreboard empty)", if_dout);
         end else begin
            e_word = exp_q.pop_front();
            chk("read_data", int'(if_dout), int'(e_word));
         end
      end
   end

   task automatic cyc(input bit w, input bit wc, input bit r, input bit rc, input logic [DW-1:0] d);
      wr = w; wce = wc; rd = r; rce = rc; din = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      wr = 0; wce = 0; rd = 0; rce = 0; din = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_usedw", int'(usedw), 0);
      chk("rst_full_n", int'(if_full_n), 0);
      chk("rst_empty_n", int'(if_empty_n), 0);
      chk("rst_afull_n", int'(if_almost_full_n), 1);
      reset = 1'b0;
      #1;
      chk("rel_full_n", int'(if_full_n), 1);

      // single word: 2-cycle write-to-read latency
      cyc(1, 1, 0, 0, 8'h01);
      chk("t1_empty_n_n", int'(if_empty_n), 0);
      chk("t1_usedw_n", int'(usedw), 1);
      cyc(0, 0, 0, 0, 8'h00);
      chk("t1_empty_n_n1", int'(if_empty_n), 1);
      chk("t1_dout", int'(if_dout), 1);
      cyc(0, 0, 1, 1, 8'h00);
      chk("t1_empty_after_rd", int'(if_empty_n), 0);
      chk("t1_usedw_after_rd", int'(usedw), 0);

      // fill to capacity, blocked write, drain in order
      for (int i = 0; i < DEPTH + 1; i++) cyc(1, 1, 0, 0, DW'(i));
      chk("t2_usedw_full", int'(usedw), DEPTH + 1);
      chk("t2_full_n", int'(if_full_n), 0);
      chk("t2_addr", int'(srl_addr), DEPTH - 1);
      wr = 1; wce = 1; din = 8'h63;
      #1;
      chk("t2_we_blocked", int'(srl_we), 0);
      cyc(1, 1, 1, 1, 8'h63);
      chk("t2_full_n_rise", int'(if_full_n), 1);
      chk("t2_usedw_1rd", int'(usedw), DEPTH);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 1, 8'h00);
      chk("t2_drained", int'(usedw), 0);

      // streaming: write and read every cycle
      for (int i = 0; i < 100; i++) begin
         cyc(1, 1, 1, 1, DW'(i + 8'h20));
         if (i >= 1) begin
            chk("t3_empty_n", int'(if_empty_n), 1);
            chk("t3_usedw", int'(usedw), 2);
         end
      end
      repeat (3) cyc(0, 0, 1, 1, 8'h00);
      chk("t3_drained", int'(usedw), 0);

      // clock enables low: requests ignored
      cyc(1, 1, 0, 0, 8'h33);
      cyc(1, 1, 0, 0, 8'h44);
      cyc(0, 0, 0, 0, 8'h00);
      chk("t4_dout", int'(if_dout), 8'h33);
      repeat (5) begin
         cyc(1, 0, 0, 0, 8'h77);
         chk("t4_wce_usedw", int'(usedw), 2);
      end
      repeat (5) begin
         cyc(0, 0, 1, 0, 8'h00);
         chk("t4_rce_dout", int'(if_dout), 8'h33);
         chk("t4_rce_usedw", int'(usedw), 2);
      end
      repeat (2) cyc(0, 0, 1, 1, 8'h00);

      // almost-full threshold
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, DW'(8'h50 + i));
      cyc(0, 0, 0, 0, 8'h00);
      chk("t5_afull_5", int'(if_almost_full_n), 1);
      cyc(1, 1, 0, 0, 8'h55);
      chk("t5_afull_6", int'(if_almost_full_n), 0);
      cyc(0, 0, 1, 1, 8'h00);
      chk("t5_afull_rd", int'(if_almost_full_n), 1);
      repeat (6) cyc(0, 0, 1, 1, 8'h00);

      // asynchronous reset mid-cycle with data held
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, DW'(8'hB0 + i));
      cyc(0, 0, 0, 0, 8'h00);
      wr = 1; wce = 1; din = 8'hEE;
      #2;
      reset = 1'b1;
      #1;
      chk("t6_empty_n", int'(if_empty_n), 0);
      chk("t6_usedw", int'(usedw), 0);
      chk("t6_srl_we", int'(srl_we), 0);
      chk("t6_full_n", int'(if_full_n), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      wr = 0; wce = 0;
      #1;
      chk("t6_full_n_rel", int'(if_full_n), 1);
      cyc(1, 1, 0, 0, 8'hA5);
      cyc(0, 0, 0, 0, 8'h00);
      chk("t6_dout", int'(if_dout), 8'hA5);
      chk("t6_usedw1", int'(usedw), 1);
      cyc(0, 0, 1, 1, 8'h00);
      chk("t6_usedw0", int'(usedw), 0);

      // randomized traffic: write-heavy, then read-heavy, then mixed
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 250; i++) begin
            cyc(($urandom_range(0, 3) != 0) ? (ph != 1) : (ph == 1),
                ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) != 0) ? (ph != 0) : (ph == 0),
                ($urandom_range(0, 7) != 0),
                DW'($urandom));
         end
      end
      repeat (DEPTH + 4) cyc(0, 0, 1, 1, 8'h00);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_usedw", int'(usedw), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/srl_fifo_ctrl.md
Name: srl_fifo_ctrl

Overview:
- Control and output stage for the SRL-based stream/start FIFOs that sit between dataflow PEs in the Linear_Layer fabric.
- Drives the shift-register storage through its write-enable and read-address ports, tracks occupancy, and generates the full/empty handshakes.
- Holds the oldest word in a registered first-word-fall-through output stage. Total capacity is DEPTH+1 words.
- The SRL storage is instantiated alongside this block, not inside it.

Parameters:
- DATA_WIDTH, 1, width of the stored word.
- ADDR_WIDTH, 3, width of srl_addr; 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 8, number of SRL stages.
- AFULL_THRESH, 8, usedw value at or above which if_almost_full_n drops.

Ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous active-high reset.
- if_write_ce, in, 1, write clock enable.
- if_write, in, 1, write request.
- if_full_n, out, 1, high when a write can be accepted.
- if_almost_full_n, out, 1, low when usedw >= AFULL_THRESH.
- if_read_ce, in, 1, read clock enable.
- if_read, in, 1, read request.
- if_empty_n, out, 1, high when if_dout holds a valid word.
- if_dout, out, DATA_WIDTH, registered head-of-FIFO word.
- usedw, out, ADDR_WIDTH+1, total words held (SRL plus output register).
- srl_we, out, 1, shift-register write/shift enable.
- srl_addr, out, ADDR_WIDTH, shift-register read address.
- srl_dout, in, DATA_WIDTH, shift-register combinational read data.

Behaviour:
- State: srl_count (0..DEPTH), dout_vld, and the dout register.
- push = if_write & if_write_ce & if_full_n.
- pop = if_read & if_read_ce & dout_vld.
- load = (srl_count != 0) & (~dout_vld | pop).
- srl_we = push (combinational). Write data goes straight to the SRL din; this block does not see it.
- srl_addr = srl_count-1 when srl_count > 0, else 0 (combinational). This is the address of the oldest SRL word.
- On load: dout <= srl_dout and dout_vld <= 1.
- On pop without load: dout_vld <= 0, and dout holds its old value.
- srl_count <= srl_count + push - load.
- A simultaneous push and load is legal. The read uses the pre-shift address, and the next address equals the new srl_count-1.
- if_full_n = ~reset & (srl_count != DEPTH). It is forced low while reset is asserted.
- if_empty_n = dout_vld.
- usedw = srl_count + dout_vld, combinational from state.
- if_almost_full_n = (usedw < AFULL_THRESH).
- Latency:
  - A write accepted at edge N makes if_empty_n high after edge N+1, with no bypass. This is 2 cycles of write-to-read latency.
  - pop at edge N with srl_count > 0 presents the next word after edge N, so back-to-back reads are possible.
- Ignored requests:
  - Write while if_full_n is low: srl_we stays 0 and no state changes.
  - Read while if_empty_n is low: no state changes.
  - A request with ce low is ignored.
- Full boundary:
  - Full means srl_count = DEPTH; usedw can reach DEPTH+1.
  - A read at full does not admit a same-cycle write, because if_full_n is already low.
  - if_full_n rises the cycle after the pop/load.
- Wrap-around: none. The SRL shifts rather than using pointers, and srl_count saturates by construction.
- Reset (asynchronous, any time including mid-burst):
  - State: srl_count=0, dout_vld=0, dout=0.
  - Outputs during reset: if_empty_n=0, usedw=0, srl_we=0, if_almost_full_n=1, if_full_n=0.
  - if_full_n returns high in the first cycle after reset deasserts.
  - SRL contents are not cleared and are treated as don't-care.

Test Plan:
- Reset, then write 0x1 once (DATA_WIDTH=4) -> srl_we pulses 1 cycle with srl_addr=0; if_empty_n rises 2 edges after the write; if_dout=0x1; usedw=1; read -> if_empty_n=0, usedw=0.
- DEPTH=8: write 9 words 0..8 with no reads -> if_full_n low after the 9th, usedw=9, srl_addr=7.
  - A 10th write is ignored (srl_we=0).
  - Reads return 0..8 in order; if_full_n rises the cycle after the first read.
- Continuous write and read every cycle with ce high, 100 words incrementing -> output order identical, no drops; steady state has srl_count at 1 and if_empty_n constantly high after the initial 2-cycle latency.
- if_write_ce=0 with if_write=1 for 5 cycles -> srl_we=0 and usedw unchanged. Then if_read_ce=0 with if_read=1 while non-empty -> if_dout and usedw unchanged.
- AFULL_THRESH=6: write 5 words -> if_almost_full_n=1; 6th word -> 0; one read -> 1.
- Load 5 words, then assert reset asynchronously mid-cycle -> if_empty_n, usedw and srl_we drop immediately and if_full_n=0. After release: if_full_n=1, and the next write/read returns the new word only.
